// File: rtl/mips_cpu_harvard_mem_bridge_if.sv
// mips_cpu_harvard_mem_bridge_if
//   Groups every bus signal of the Harvard CPU memory bridge: the host run
//   enable, the CPU-facing combinational instruction/data ports and the two
//   Avalon-style wait-state memory ports.
//   Modports:
//     slave  - the bridge's view (drives cpu_clk_enable, buffered read data,
//              memory requests and bus_error).
//     master - the environment's view (host, CPU and both memories).
interface mips_cpu_harvard_mem_bridge_if;
   logic        host_clk_enable;
   logic        cpu_clk_enable;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic [31:0] data_address;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;
   logic [31:0] imem_address;
   logic        imem_read;
   logic        imem_waitrequest;
   logic [31:0] imem_readdata;
   logic [31:0] dmem_address;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_writedata;
   logic        dmem_waitrequest;
   logic [31:0] dmem_readdata;
   logic        bus_error;

   modport slave (
      input  host_clk_enable,
      output cpu_clk_enable,
      input  instr_address,
      output instr_readdata,
      input  data_address,
      input  data_read,
      input  data_write,
      input  data_writedata,
      output data_readdata,
      output imem_address,
      output imem_read,
      input  imem_waitrequest,
      input  imem_readdata,
      output dmem_address,
      output dmem_read,
      output dmem_write,
      output dmem_writedata,
      input  dmem_waitrequest,
      input  dmem_readdata,
      output bus_error
   );

   modport master (
      output host_clk_enable,
      input  cpu_clk_enable,
      output instr_address,
      input  instr_readdata,
      output data_address,
      output data_read,
      output data_write,
      output data_writedata,
      input  data_readdata,
      input  imem_address,
      input  imem_read,
      output imem_waitrequest,
      output imem_readdata,
      input  dmem_address,
      input  dmem_read,
      input  dmem_write,
      input  dmem_writedata,
      output dmem_waitrequest,
      output dmem_readdata,
      input  bus_error
   );
endinterface

// File: rtl/mips_cpu_harvard_mem_bridge.sv
// mips_cpu_harvard_mem_bridge
//   Sequences a Harvard CPU with combinational instruction/data ports against
//   two wait-state memories. Each instruction is fetched, optionally performs
//   one data access, then the CPU is stepped by a single cpu_clk_enable pulse.
//   Read data is buffered so the CPU sees stable values while enabled. A wait
//   counter aborts a stuck request, raises sticky bus_error and halts.
//   Parameters:
//     TIMEOUT_CYCLES - max consecutive waitrequest cycles per request (0 = off)
//   Ports:
//     clk   - clock
//     reset - synchronous, active-high
//     bus   - mips_cpu_harvard_mem_bridge_if.slave (host, CPU, imem, dmem)
module mips_cpu_harvard_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                                clk,
   input  logic                                reset,
   mips_cpu_harvard_mem_bridge_if.slave        bus
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DATA  = 2'd1,
      STEP  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state_r,          state_nxt_s;
   logic        check_r,          check_nxt_s;
   logic        imem_read_r,      imem_read_nxt_s;
   logic        dmem_read_r,      dmem_read_nxt_s;
   logic        dmem_write_r,     dmem_write_nxt_s;
   logic [31:0] dmem_address_r,   dmem_address_nxt_s;
   logic [31:0] dmem_writedata_r, dmem_writedata_nxt_s;
   logic [31:0] instr_buf_r,      instr_buf_nxt_s;
   logic [31:0] data_buf_r,       data_buf_nxt_s;
   logic [31:0] wait_cnt_r,       wait_cnt_nxt_s;
   logic        bus_error_r,      bus_error_nxt_s;
   logic [31:0] wait_inc_s;

   // True once a waiting request has accumulated the maximum allowed wait cycles.
   function automatic logic timed_out(input logic [31:0] cnt);
      return (TIMEOUT_CYCLES != 32'd0) && (cnt >= TIMEOUT_CYCLES);
   endfunction

   // Next-state and next-output logic for the sequencing FSM.
   always_comb begin
      state_nxt_s          = state_r;
      check_nxt_s          = check_r;
      imem_read_nxt_s      = imem_read_r;
      dmem_read_nxt_s      = dmem_read_r;
      dmem_write_nxt_s     = dmem_write_r;
      dmem_address_nxt_s   = dmem_address_r;
      dmem_writedata_nxt_s = dmem_writedata_r;
      instr_buf_nxt_s      = instr_buf_r;
      data_buf_nxt_s       = data_buf_r;
      wait_cnt_nxt_s       = wait_cnt_r;
      bus_error_nxt_s      = bus_error_r;
      wait_inc_s           = wait_cnt_r + 32'd1;

      case (state_r)
         FETCH: begin
            if (check_r) begin
               // The CPU now decodes the freshly buffered instruction, so its
               // strobes are valid; launch the data request registered.
               check_nxt_s          = 1'b0;
               wait_cnt_nxt_s       = 32'd0;
               dmem_address_nxt_s   = bus.data_address;
               dmem_writedata_nxt_s = bus.data_writedata;
               if (bus.data_write) begin
                  dmem_write_nxt_s = 1'b1;
                  state_nxt_s      = DATA;
               end else if (bus.data_read) begin
                  dmem_read_nxt_s  = 1'b1;
                  state_nxt_s      = DATA;
               end else begin
                  state_nxt_s      = STEP;
               end
            end else if (imem_read_r) begin
               if (!bus.imem_waitrequest) begin
                  instr_buf_nxt_s = bus.imem_readdata;
                  imem_read_nxt_s = 1'b0;
                  check_nxt_s     = 1'b1;
                  wait_cnt_nxt_s  = 32'd0;
               end else if (timed_out(wait_inc_s)) begin
                  imem_read_nxt_s = 1'b0;
                  bus_error_nxt_s = 1'b1;
                  wait_cnt_nxt_s  = wait_inc_s;
                  state_nxt_s     = HALT;
               end else begin
                  wait_cnt_nxt_s  = wait_inc_s;
               end
            end else if (bus.host_clk_enable) begin
               imem_read_nxt_s = 1'b1;
               wait_cnt_nxt_s  = 32'd0;
            end else begin
               imem_read_nxt_s = 1'b0;
            end
         end

         DATA: begin
            if (dmem_read_r || dmem_write_r) begin
               if (!bus.dmem_waitrequest) begin
                  // Writes never touch the read buffer.
                  if (dmem_read_r) begin
                     data_buf_nxt_s = bus.dmem_readdata;
                  end else begin
                     data_buf_nxt_s = data_buf_r;
                  end
                  dmem_read_nxt_s  = 1'b0;
                  dmem_write_nxt_s = 1'b0;
                  wait_cnt_nxt_s   = 32'd0;
                  state_nxt_s      = STEP;
               end else if (timed_out(wait_inc_s)) begin
                  dmem_read_nxt_s  = 1'b0;
                  dmem_write_nxt_s = 1'b0;
                  bus_error_nxt_s  = 1'b1;
                  wait_cnt_nxt_s   = wait_inc_s;
                  state_nxt_s      = HALT;
               end else begin
                  wait_cnt_nxt_s   = wait_inc_s;
               end
            end else begin
               state_nxt_s = STEP;
            end
         end

         STEP: begin
            // The enabled cycle is the CPU step; the next fetch is issued at
            // the same edge so a zero-wait instruction costs three cycles.
            if (bus.host_clk_enable) begin
               imem_read_nxt_s = 1'b1;
               wait_cnt_nxt_s  = 32'd0;
               state_nxt_s     = FETCH;
            end else begin
               state_nxt_s     = STEP;
            end
         end

         HALT: begin
            imem_read_nxt_s  = 1'b0;
            dmem_read_nxt_s  = 1'b0;
            dmem_write_nxt_s = 1'b0;
            check_nxt_s      = 1'b0;
            state_nxt_s      = HALT;
         end

         default: begin
            imem_read_nxt_s  = 1'b0;
            dmem_read_nxt_s  = 1'b0;
            dmem_write_nxt_s = 1'b0;
            check_nxt_s      = 1'b0;
            state_nxt_s      = FETCH;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= FETCH;
         check_r          <= 1'b0;
         imem_read_r      <= 1'b0;
         dmem_read_r      <= 1'b0;
         dmem_write_r     <= 1'b0;
         dmem_address_r   <= 32'd0;
         dmem_writedata_r <= 32'd0;
         instr_buf_r      <= 32'd0;
         data_buf_r       <= 32'd0;
         wait_cnt_r       <= 32'd0;
         bus_error_r      <= 1'b0;
      end else begin
         state_r          <= state_nxt_s;
         check_r          <= check_nxt_s;
         imem_read_r      <= imem_read_nxt_s;
         dmem_read_r      <= dmem_read_nxt_s;
         dmem_write_r     <= dmem_write_nxt_s;
         dmem_address_r   <= dmem_address_nxt_s;
         dmem_writedata_r <= dmem_writedata_nxt_s;
         instr_buf_r      <= instr_buf_nxt_s;
         data_buf_r       <= data_buf_nxt_s;
         wait_cnt_r       <= wait_cnt_nxt_s;
         bus_error_r      <= bus_error_nxt_s;
      end
   end

   // The CPU's PC only becomes valid after the edge that launches the fetch,
   // so the instruction address is passed through while the registered read
   // is pending; the PC is frozen then because cpu_clk_enable is low.
   assign bus.imem_address   = imem_read_r ? bus.instr_address : 32'd0;
   assign bus.imem_read      = imem_read_r;
   assign bus.dmem_address   = dmem_address_r;
   assign bus.dmem_read      = dmem_read_r;
   assign bus.dmem_write     = dmem_write_r;
   assign bus.dmem_writedata = dmem_writedata_r;
   assign bus.instr_readdata = instr_buf_r;
   assign bus.data_readdata  = data_buf_r;
   assign bus.bus_error      = bus_error_r;
   // Follows the host enable within the step cycle so a paused host never
   // produces a partial pulse.
   assign bus.cpu_clk_enable = (state_r == STEP) && bus.host_clk_enable;

endmodule

// File: tb/tb_mips_cpu_harvard_mem_bridge.sv
// tb_mips_cpu_harvard_mem_bridge
//   Directed bench: a tiny CPU model (PC + load/store decode), an instruction
//   ROM and a data memory with per-address wait states. Expected fetch
//   addresses, memory transactions and per-step buffer contents are queued
//   up front and compared by a negedge monitor as the bridge produces them.
module tb_mips_cpu_harvard_mem_bridge;

   localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
   localparam logic [31:0] SLOW_IADDR = 32'hBFC0_0018;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] data;
   } step_exp_t;

   logic clk = 1'b0;
   logic reset;

   mips_cpu_harvard_mem_bridge_if bif();

   mips_cpu_harvard_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   logic [31:0] prog [0:15];
   logic [31:0] pc;
   logic [31:0] ioff;
   logic        imem_stuck = 1'b0;
   int          iwcnt = 0;
   int          dwcnt = 0;
   int          cyc = 0;
   int          pulse_cnt = 0;
   int          dread_cycles = 0;
   int          dwrite_cycles = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          ecnt = 0;

   logic [31:0] imem_q [$];
   dmem_exp_t   dmem_q [$];
   step_exp_t   step_q [$];
   int          pulse_t [$];
   dmem_exp_t   dm_e;
   step_exp_t   st_e;

   function automatic int dwaits(input logic [31:0] a);
      if (a == 32'h0000_0100) return 5;
      else if (a == 32'h0000_0200) return 100000;
      else return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int k = 0;
      while (pulse_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("pulse_wait", pulse_cnt, n);
   endtask

   // CPU model: PC advances on each enabled cycle.
   always @(posedge clk) begin
      if (reset) pc <= RESET_PC;
      else if (bif.cpu_clk_enable) pc <= pc + 32'd4;
   end
   assign bif.instr_address = pc;

   // CPU decode, instruction ROM and data memory responses.
   always_comb begin
      bif.data_read        = (bif.instr_readdata[31:26] == 6'h23);
      bif.data_write       = (bif.instr_readdata[31:26] == 6'h2B);
      bif.data_address     = {{16{bif.instr_readdata[15]}}, bif.instr_readdata[15:0]};
      bif.data_writedata   = 32'h1234_5678;
      ioff                 = bif.imem_address - RESET_PC;
      bif.imem_readdata    = (ioff < 32'd64) ? prog[ioff[5:2]] : 32'h0;
      bif.imem_waitrequest = bif.imem_read &&
                             (imem_stuck || (bif.imem_address == SLOW_IADDR && iwcnt < 4));
      bif.dmem_readdata    = 32'hDEAD_BEEF;
      bif.dmem_waitrequest = (bif.dmem_read || bif.dmem_write) &&
                             (dwcnt < dwaits(bif.dmem_address));
   end

   // Wait-state counters and pulse counter.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!bif.imem_read) iwcnt <= 0;
      else if (bif.imem_waitrequest) iwcnt <= iwcnt + 1;
      else iwcnt <= 0;
      if (!(bif.dmem_read || bif.dmem_write)) dwcnt <= 0;
      else if (bif.dmem_waitrequest) dwcnt <= dwcnt + 1;
      else dwcnt <= 0;
      if (bif.cpu_clk_enable) pulse_cnt <= pulse_cnt + 1;
   end

   // Scoreboard monitor: compares each completion and each step with the queues.
   always @(negedge clk) begin
      if (bif.imem_read && !bif.imem_waitrequest) begin
         if (imem_q.size() > 0) chk("imem_addr", bif.imem_address, imem_q.pop_front());
         else chk("imem_extra_fetch", imem_q.size(), 32'd1);
      end
      if ((bif.dmem_read || bif.dmem_write) && !bif.dmem_waitrequest) begin
         if (dmem_q.size() > 0) begin
            dm_e = dmem_q.pop_front();
            chk("dmem_we", {31'd0, bif.dmem_write}, {31'd0, dm_e.we});
            chk("dmem_rd", {31'd0, bif.dmem_read}, {31'd0, ~dm_e.we});
            chk("dmem_addr", bif.dmem_address, dm_e.addr);
            if (dm_e.we) chk("dmem_wdata", bif.dmem_writedata, dm_e.wdata);
         end else begin
            chk("dmem_extra_access", dmem_q.size(), 32'd1);
         end
      end
      if (bif.dmem_read) dread_cycles++;
      if (bif.dmem_write) dwrite_cycles++;
      if (bif.cpu_clk_enable) begin
         pulse_t.push_back(cyc);
         if (step_q.size() > 0) begin
            st_e = step_q.pop_front();
            chk("step_instr", bif.instr_readdata, st_e.instr);
            chk("step_data", bif.data_readdata, st_e.data);
         end else begin
            chk("step_extra_pulse", step_q.size(), 32'd1);
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) prog[i] = 32'h0;
      prog[0] = 32'h0022_1821;  // addu
      prog[1] = 32'h2442_0001;  // addiu
      prog[2] = 32'h0043_1021;  // addu
      prog[3] = 32'h0064_2021;  // addu
      prog[4] = 32'h8C03_0100;  // lw   0x100
      prog[5] = 32'hAC03_1000;  // sw   0x1000
      prog[6] = 32'h2484_0004;  // addiu (slow fetch)
      prog[7] = 32'h0085_2821;  // addu
      prog[8] = 32'h8C03_0200;  // lw   0x200 (never completes)

      reset = 1'b1;
      bif.host_clk_enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_clk_enable", {31'd0, bif.cpu_clk_enable}, 32'd0);
      chk("rst_imem_read", {31'd0, bif.imem_read}, 32'd0);
      chk("rst_dmem_read", {31'd0, bif.dmem_read}, 32'd0);
      chk("rst_dmem_write", {31'd0, bif.dmem_write}, 32'd0);
      chk("rst_bus_error", {31'd0, bif.bus_error}, 32'd0);
      chk("rst_instr_readdata", bif.instr_readdata, 32'd0);
      chk("rst_data_readdata", bif.data_readdata, 32'd0);
      chk("rst_dmem_writedata", bif.dmem_writedata, 32'd0);
      chk("rst_imem_address", bif.imem_address, 32'd0);
      chk("rst_dmem_address", bif.dmem_address, 32'd0);

      // Program run: four ALU ops, a slow LW, an SW, then host-enable pauses.
      for (int i = 0; i < 9; i++) imem_q.push_back(RESET_PC + 32'(4 * i));
      for (int i = 0; i < 8; i++)
         step_q.push_back('{prog[i], (i < 4) ? 32'h0 : 32'hDEAD_BEEF});
      dmem_q.push_back('{1'b0, 32'h0000_0100, 32'h0});
      dmem_q.push_back('{1'b1, 32'h0000_1000, 32'h1234_5678});

      @(posedge clk); #1;
      reset = 1'b0;
      bif.host_clk_enable = 1'b1;
      wait_pulses(6, 200);
      chk("period_alu1", pulse_t[1] - pulse_t[0], 32'd3);
      chk("period_alu2", pulse_t[2] - pulse_t[1], 32'd3);
      chk("period_alu3", pulse_t[3] - pulse_t[2], 32'd3);
      chk("period_lw_waits", pulse_t[4] - pulse_t[3], 32'd9);
      chk("period_sw", pulse_t[5] - pulse_t[4], 32'd4);
      chk("lw_read_cycles", dread_cycles, 32'd6);
      chk("sw_write_cycles", dwrite_cycles, 32'd1);
      chk("sw_keeps_readdata", bif.data_readdata, 32'hDEAD_BEEF);

      // Host enable dropped while the slow fetch of prog[6] waits.
      @(posedge clk); #1;
      bif.host_clk_enable = 1'b0;
      repeat (10) @(negedge clk);
      chk("pause_fetch_pulses", pulse_cnt, 32'd6);
      chk("pause_fetch_done", {31'd0, bif.imem_read}, 32'd0);
      chk("pause_fetch_instr", bif.instr_readdata, prog[6]);
      chk("pause_fetch_cke", {31'd0, bif.cpu_clk_enable}, 32'd0);
      @(posedge clk); #1;
      bif.host_clk_enable = 1'b1;
      wait_pulses(7, 20);

      // Host enable low across the whole STEP of prog[7].
      @(posedge clk); #1;
      bif.host_clk_enable = 1'b0;
      repeat (6) @(negedge clk);
      chk("pause_step_pulses", pulse_cnt, 32'd7);
      chk("pause_step_cke", {31'd0, bif.cpu_clk_enable}, 32'd0);
      chk("pause_step_instr", bif.instr_readdata, prog[7]);
      @(posedge clk); #1;
      bif.host_clk_enable = 1'b1;
      wait_pulses(8, 20);

      // Reset while the LW to 0x200 is stuck waiting.
      ecnt = 0;
      while (!bif.dmem_read && ecnt < 20) begin
         @(negedge clk);
         ecnt++;
      end
      repeat (3) @(negedge clk);
      chk("lw2_read_pending", {31'd0, bif.dmem_read}, 32'd1);
      chk("lw2_single_pulse", pulse_cnt, 32'd8);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("lw2_read_before_rst", {31'd0, bif.dmem_read}, 32'd1);
      @(negedge clk);
      chk("mid_rst_dmem_read", {31'd0, bif.dmem_read}, 32'd0);
      chk("mid_rst_imem_read", {31'd0, bif.imem_read}, 32'd0);
      chk("mid_rst_cke", {31'd0, bif.cpu_clk_enable}, 32'd0);
      chk("mid_rst_instr", bif.instr_readdata, 32'd0);
      chk("mid_rst_data", bif.data_readdata, 32'd0);
      chk("mid_rst_dmem_address", bif.dmem_address, 32'd0);
      chk("mid_rst_dmem_writedata", bif.dmem_writedata, 32'd0);

      // Restart from FETCH at the reset PC.
      imem_q.push_back(RESET_PC);
      imem_q.push_back(RESET_PC + 32'd4);
      step_q.push_back('{prog[0], 32'h0});
      @(posedge clk); #1;
      reset = 1'b0;
      wait_pulses(9, 20);
      @(posedge clk); #1;
      bif.host_clk_enable = 1'b0;
      repeat (6) @(negedge clk);
      chk("restart_pulses", pulse_cnt, 32'd9);
      chk("restart_next_instr", bif.instr_readdata, prog[1]);

      // Instruction memory stuck: timeout after 8 wait cycles.
      @(posedge clk); #1;
      reset = 1'b1;
      imem_stuck = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      bif.host_clk_enable = 1'b1;
      ecnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bif.bus_error) break;
         if (bif.imem_read) ecnt++;
      end
      chk("timeout_wait_cycles", ecnt, 32'd8);
      chk("timeout_bus_error", {31'd0, bif.bus_error}, 32'd1);
      chk("timeout_imem_read", {31'd0, bif.imem_read}, 32'd0);
      repeat (10) @(negedge clk);
      chk("halt_no_pulse", pulse_cnt, 32'd9);
      chk("halt_cke", {31'd0, bif.cpu_clk_enable}, 32'd0);
      chk("halt_imem_read", {31'd0, bif.imem_read}, 32'd0);
      chk("halt_bus_error_sticky", {31'd0, bif.bus_error}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      bif.host_clk_enable = 1'b0;
      imem_stuck = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_clears_bus_error", {31'd0, bif.bus_error}, 32'd0);

      chk("imem_queue_drained", imem_q.size(), 32'd0);
      chk("dmem_queue_drained", dmem_q.size(), 32'd0);
      chk("step_queue_drained", step_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
